// File: rtl/reg_file_dbg.sv
// reg_file_dbg: 16x16 CPU register file with a serialized debug access port.
//
// The CPU gets two combinational read ports and one writeback port. A
// req/gnt/rsp debug channel can preload and inspect registers. A debug write
// uses the write port only in a cycle where the CPU is not writing. If that
// write waits too long, cpuStall asks the CPU to hold writeback.
//
// Optional feature: define REG_BYPASS_EN to forward same-cycle writeback data
// onto the read ports (write-before-read). It is off by default.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   srcReg1/2, srcData1/2    CPU read address / combinational read data
//   dstReg, dstData, writeReg CPU writeback port
//   dbgReq, dbgWe, dbgAddr, dbgWdata  debug command (held until dbgGnt)
//   dbgGnt                   1-cycle pulse when the command is captured
//   dbgRspValid, dbgRdata    1-cycle completion pulse; read data or write echo
//   cpuStall                 request for the CPU to hold writeback
module reg_file_dbg #(
    parameter  int DATA_W       = 16,
    parameter  int NUM_REGS     = 16,
    parameter  int STARVE_LIMIT = 4,
    localparam int AW           = $clog2(NUM_REGS),
    localparam int CW           = $clog2(STARVE_LIMIT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     srcReg1,
    input  logic [AW-1:0]     srcReg2,
    output logic [DATA_W-1:0] srcData1,
    output logic [DATA_W-1:0] srcData2,
    input  logic [AW-1:0]     dstReg,
    input  logic [DATA_W-1:0] dstData,
    input  logic              writeReg,
    input  logic              dbgReq,
    input  logic              dbgWe,
    input  logic [AW-1:0]     dbgAddr,
    input  logic [DATA_W-1:0] dbgWdata,
    output logic              dbgGnt,
    output logic              dbgRspValid,
    output logic [DATA_W-1:0] dbgRdata,
    output logic              cpuStall
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    state_t              state_q, state_d;
    logic                cmd_we_q, cmd_we_d;
    logic [AW-1:0]       cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
    logic [CW-1:0]       starve_q, starve_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];

    logic                cpu_we;
    logic                dbg_we;
    logic                gnt;
    logic                cpu_hit;

    // R0 is hardwired to zero. A write to address 0 never enables a store.
    assign cpu_we  = writeReg && (dstReg != '0);
    // A debug read returns what the register holds after this edge's writeback.
    assign cpu_hit = cpu_we && (dstReg == cmd_addr_q);

    always_comb begin
        state_d     = state_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        starve_d    = starve_q;
        rdata_d     = rdata_q;
        dbg_we      = 1'b0;
        gnt         = 1'b0;
        case (state_q)
            IDLE: begin
                if (dbgReq) begin
                    gnt         = 1'b1;
                    cmd_we_d    = dbgWe;
                    cmd_addr_d  = dbgAddr;
                    cmd_wdata_d = dbgWdata;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                if (!cmd_we_q) begin
                    rdata_d  = cpu_hit ? dstData : regs_q[cmd_addr_q];
                    starve_d = '0;
                    state_d  = RESP;
                end else if (!writeReg) begin
                    // The CPU is idle this cycle, so the debug write takes the port.
                    dbg_we   = (cmd_addr_q != '0);
                    rdata_d  = cmd_wdata_q;
                    starve_d = '0;
                    state_d  = RESP;
                end else if (starve_q < LIMIT) begin
                    starve_d = starve_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            starve_q    <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            starve_q    <= starve_d;
            rdata_q     <= rdata_d;
        end
    end

    // dbg_we requires writeReg == 0, so the two store enables are never both active.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (cpu_we) begin
            regs_q[dstReg] <= dstData;
        end else if (dbg_we) begin
            regs_q[cmd_addr_q] <= cmd_wdata_q;
        end
    end

    // Outputs are forced low while reset is held. The FSM state only
    // updates at the edge.
    assign dbgGnt      = gnt && !rst;
    assign dbgRspValid = (state_q == RESP) && !rst;
    assign cpuStall    = (state_q == EXEC) && cmd_we_q && (starve_q >= LIMIT) && !rst;
    assign dbgRdata    = rdata_q;

`ifdef REG_BYPASS_EN
    assign srcData1 = (cpu_we && dstReg == srcReg1) ? dstData : regs_q[srcReg1];
    assign srcData2 = (cpu_we && dstReg == srcReg2) ? dstData : regs_q[srcReg2];
`else
    assign srcData1 = regs_q[srcReg1];
    assign srcData2 = regs_q[srcReg2];
`endif

endmodule

// File: tb/tb_reg_file_dbg.sv
// tb_reg_file_dbg: testbench for reg_file_dbg. Expected debug responses are
// queued when a grant is observed and compared when dbgRspValid fires.
module tb_reg_file_dbg;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  srcReg1, srcReg2, dstReg, dbgAddr;
    logic [15:0] srcData1, srcData2, dstData, dbgWdata, dbgRdata;
    logic        writeReg, dbgReq, dbgWe, dbgGnt, dbgRspValid, cpuStall;

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [15:0] exp;
        int          gcyc;
        bit          lat;
    } sb_t;
    sb_t sb_q[$];

    reg_file_dbg dut (
        .clk(clk), .rst(rst),
        .srcReg1(srcReg1), .srcReg2(srcReg2),
        .srcData1(srcData1), .srcData2(srcData2),
        .dstReg(dstReg), .dstData(dstData), .writeReg(writeReg),
        .dbgReq(dbgReq), .dbgWe(dbgWe), .dbgAddr(dbgAddr), .dbgWdata(dbgWdata),
        .dbgGnt(dbgGnt), .dbgRspValid(dbgRspValid), .dbgRdata(dbgRdata),
        .cpuStall(cpuStall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Response monitor.
    always @(negedge clk) begin
        if (dbgRspValid) begin
            if (sb_q.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                chk("rsp_data", dbgRdata, e.exp);
                if (e.lat) chk("rsp_latency", cyc - e.gcyc, 2);
            end
        end
    end

    // Call at posedge+1. Returns at posedge+1 of the cycle after the grant.
    task automatic dbg_issue(input logic we, input logic [3:0] a, input logic [15:0] d,
                             input logic [15:0] exp, input bit lat);
        bit got;
        got = 0;
        dbgReq = 1'b1; dbgWe = we; dbgAddr = a; dbgWdata = d;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (dbgGnt) begin
                got = 1;
                sb_q.push_back('{exp: exp, gcyc: cyc, lat: lat});
            end
            @(posedge clk); #1;
        end
        dbgReq = 1'b0;
        chk("gnt_seen", got, 1);
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("rsp_drained", sb_q.size(), 0);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [15:0] exp);
        srcReg1 = a; srcReg2 = a;
        #1;
        chk(tag, srcData1, exp);
        chk(tag, srcData2, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; srcReg1 = 0; srcReg2 = 0; dstReg = 0; dstData = 0; writeReg = 0;
        dbgReq = 1'b1; dbgWe = 1'b1; dbgAddr = 4'd3; dbgWdata = 16'h5a5a;

        // 1. Reset: outputs are low even with a request pending, and all registers are 0.
        repeat (2) begin
            @(negedge clk);
            chk("rst_gnt", dbgGnt, 0);
            chk("rst_rsp", dbgRspValid, 0);
            chk("rst_stall", cpuStall, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0; dbgReq = 1'b0;
        chk("rst_rdata", dbgRdata, 0);
        for (int i = 0; i < 16; i++) rd_chk("rst_reg", 4'(i), 16'h0);

        // 2. Debug writes with no contention.
        @(posedge clk); #1;
        dbg_issue(1'b1, 4'd4, 16'h0010, 16'h0010, 1);
        wait_rsp();
        dbg_issue(1'b1, 4'd5, 16'h0003, 16'h0003, 1);
        wait_rsp();
        srcReg1 = 4'd4; srcReg2 = 4'd5; #1;
        chk("r4_val", srcData1, 16'h0010);
        chk("r5_val", srcData2, 16'h0003);

        // 3. CPU write and same-cycle read.
        @(posedge clk); #1;
        writeReg = 1'b1; dstReg = 4'd7; dstData = 16'hBEEF; srcReg1 = 4'd7;
        @(negedge clk);
`ifdef REG_BYPASS_EN
        chk("bypass_same", srcData1, 16'hBEEF);
`else
        chk("nobypass_same", srcData1, 16'h0000);
`endif
        @(posedge clk); #1;
        writeReg = 1'b0;
        @(negedge clk);
        chk("r7_next", srcData1, 16'hBEEF);

        // 4. Starved debug write. writeReg is held for cycles N..N+5.
        @(posedge clk); #1;
        writeReg = 1'b1; dstReg = 4'd9; dstData = 16'h5555; srcReg1 = 4'd2;
        dbg_issue(1'b1, 4'd2, 16'h1234, 16'h1234, 0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("starve_stall", cpuStall, (k >= 5) ? 1 : 0);
            chk("starve_r2", srcData1, 16'h0);
            @(posedge clk); #1;
        end
        writeReg = 1'b0;
        @(negedge clk);
        chk("starve_stall_land", cpuStall, 1);
        wait_rsp();
        chk("stall_clear", cpuStall, 0);
        srcReg1 = 4'd2; srcReg2 = 4'd9; #1;
        chk("r2_val", srcData1, 16'h1234);
        chk("r9_val", srcData2, 16'h5555);

        // 5. R0 write is echoed but discarded. Also test a normal read.
        dbg_issue(1'b1, 4'd0, 16'hFFFF, 16'hFFFF, 1);
        wait_rsp();
        dbg_issue(1'b0, 4'd0, 16'h0, 16'h0000, 1);
        wait_rsp();
        dbg_issue(1'b0, 4'd4, 16'h0, 16'h0010, 1);
        wait_rsp();
        rd_chk("r0_zero", 4'd0, 16'h0);

        // 6. Reset while a starved write waits in EXEC.
        writeReg = 1'b1; dstReg = 4'd9; dstData = 16'h1111;
        dbg_issue(1'b1, 4'd3, 16'hABCD, 16'hABCD, 0);
        rst = 1'b1; writeReg = 1'b0;
        @(negedge clk);
        chk("rstx_rsp", dbgRspValid, 0);
        chk("rstx_stall", cpuStall, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        repeat (3) begin
            @(negedge clk);
            chk("rstx_no_rsp", dbgRspValid, 0);
        end
        @(posedge clk); #1;
        rd_chk("rstx_r3", 4'd3, 16'h0);
        rd_chk("rstx_r9", 4'd9, 16'h0);
        dbg_issue(1'b0, 4'd3, 16'h0, 16'h0000, 1);
        wait_rsp();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
